ibwt_decoder: RTL
=================

IBWT_DECODER -- requirements
Module: ibwt_decoder

Interface
REQ-001 SHALL have parameter MAXLEN, default 1024, meaning the symbol buffer depth; addresses are 10 bits.
REQ-002 SHALL have parameter SYMS, default 256, meaning the alphabet size; symbols are 8 bits.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  load strobe; writes in_string into the L-buffer at adr.
REQ-006 adr  input  10  load address.
REQ-007 in_string  input  8  BWT (last-column) symbol being loaded.
REQ-008 length  input  10  string length n (0..1023); sampled on start.
REQ-009 primary_idx  input  10  sorted-rotation row holding the original string; sampled on start.
REQ-010 start  input  1  single-cycle decode request.
REQ-011 busy  output  1  high from the start acceptance edge until done.
REQ-012 outstring  output  8  decoded symbol.
REQ-013 out_adr  output  10  position of outstring in the original string.
REQ-014 out_valid  output  1  outstring and out_adr valid this cycle.
REQ-015 done_flag  output  1  decode finished; sticky.
REQ-016 err  output  1  primary_idx >= length at start; sticky with done_flag.

Function
REQ-017 States SHALL be IDLE, CLEAR, RANK, PREFIX, DECODE, DONE.
REQ-018 In IDLE/DONE, en=1 SHALL write L[adr]=in_string; writes while busy SHALL be ignored.
REQ-019 start with en=0 in IDLE/DONE SHALL latch length and primary_idx, clear done_flag and err, set busy, and enter CLEAR; start while busy SHALL be ignored; start with en=1 SHALL be ignored.
REQ-020 length=0 at start SHALL go directly to DONE with no out_valid and err=0.
REQ-021 primary_idx >= length (length>0) SHALL go directly to DONE with err=1 and no out_valid.
REQ-022 CLEAR SHALL zero all SYMS occurrence counters, one per cycle, in exactly 256 cycles.
REQ-023 RANK SHALL visit i=0..n-1, one per cycle: rank[i]=cnt[L[i]], then cnt[L[i]]+=1; n cycles.
REQ-024 PREFIX SHALL convert cnt into exclusive prefix sums C[c] (count of symbols < c), one symbol per cycle, in 256 cycles.
REQ-025 Counters and sums SHALL be 10 bits; no overflow is possible because n<=1023.
REQ-026 DECODE SHALL start with idx=primary_idx and k=n-1; each cycle: outstring=L[idx], out_adr=k, out_valid=1, idx=C[L[idx]]+rank[idx], k=k-1; this takes n cycles.
REQ-027 Symbols SHALL therefore be emitted last-to-first, at out_adr n-1 down to 0, one per cycle with no gaps.
REQ-028 Timing: with the start edge as edge 0, out_valid SHALL be high after edges 512+n+1 .. 512+2n, and done_flag SHALL rise at edge 512+2n+1, with busy falling at the same edge.
REQ-029 done_flag and err SHALL hold until the next accepted start or reset; outstring and out_adr SHALL hold their last values when out_valid=0.
REQ-030 The L-buffer SHALL persist across decodes, so a repeated start re-decodes the same data.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE; busy, out_valid, done_flag, err, outstring, out_adr all =0.
REQ-032 Reset mid-operation SHALL abort with no further out_valid; L-buffer contents need not be preserved or cleared.

Verification
REQ-033 Load "nnbaaa" at adr 0..5, length=6, primary_idx=3, start -> out_valid at edges 519..524 with (out_adr,outstring)=(5,a),(4,n),(3,a),(2,n),(1,a),(0,b); done_flag=1 at edge 525.
REQ-034 Load "x" at adr 0, length=1, primary_idx=0 -> single out_valid at edge 514 with (0,'x'); done_flag at edge 515.
REQ-035 length=6, primary_idx=6 -> err=1, done_flag=1, zero out_valid pulses.
REQ-036 start pulsed again during RANK, plus en writes during DECODE -> decode output identical to REQ-033.
REQ-037 rst_n low for 1 cycle during DECODE -> all outputs 0 asynchronously; a fresh start then reproduces REQ-033 exactly.
REQ-038 Random strings n in 1..1023, encoded by the golden model -> decoded output equals the original at every out_adr.

Source files
------------

// File: rtl/ibwt_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ibwt_decoder
//  Purpose  : Inverse Burrows-Wheeler transform engine. The last column (L)
//             of the sorted-rotation matrix is loaded symbol by symbol. A
//             decode request then rebuilds the original string. It works in
//             four steps:
//               CLEAR  - zero the per-symbol occurrence counters
//               RANK   - rank[i] = occurrences of L[i] in L[0..i-1]
//               PREFIX - turn the counts into first-column offsets C[c]
//               DECODE - follow the LF mapping from primary_idx and emit
//                        the symbols from the last one to the first
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    en           load strobe: L[adr] = in_string (IDLE/DONE only)
//    adr          load address
//    in_string    last-column symbol being loaded
//    length       string length n, sampled on an accepted start
//    primary_idx  row of the original string, sampled on an accepted start
//    start        single-cycle decode request
//    busy         decode in progress
//    outstring    decoded symbol
//    out_adr      position of outstring in the original string
//    out_valid    outstring/out_adr valid this cycle
//    done_flag    decode finished (sticky until next accepted start)
//    err          primary_idx >= length at start (sticky with done_flag)
// ============================================================================
module ibwt_decoder #(
   parameter int MAXLEN = 1024,
   parameter int SYMS   = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [$clog2(MAXLEN)-1:0] adr,
   input  logic [$clog2(SYMS)-1:0]   in_string,
   input  logic [$clog2(MAXLEN)-1:0] length,
   input  logic [$clog2(MAXLEN)-1:0] primary_idx,
   input  logic                      start,
   output logic                      busy,
   output logic [$clog2(SYMS)-1:0]   outstring,
   output logic [$clog2(MAXLEN)-1:0] out_adr,
   output logic                      out_valid,
   output logic                      done_flag,
   output logic                      err
);

   localparam int AW = $clog2(MAXLEN);
   localparam int SW = $clog2(SYMS);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_CLEAR  = 3'd1;
   localparam logic [2:0] c_RANK   = 3'd2;
   localparam logic [2:0] c_PREFIX = 3'd3;
   localparam logic [2:0] c_DECODE = 3'd4;
   localparam logic [2:0] c_DONE   = 3'd5;

   localparam logic [SW-1:0] c_SYM_LAST = SW'(SYMS - 1);
   localparam logic [AW-1:0] c_A_ONE    = AW'(1);
   localparam logic [SW-1:0] c_S_ONE    = SW'(1);

   // ------------------------------------------------------------------------
   // Storage. The occurrence counters are overwritten in place by the prefix
   // sums, so the same array serves as cnt[] during RANK and C[] during DECODE.
   // ------------------------------------------------------------------------
   logic [SW-1:0] r_lbuf [MAXLEN];
   logic [AW-1:0] r_rank [MAXLEN];
   logic [AW-1:0] r_cnt  [SYMS];

   // ------------------------------------------------------------------------
   // Control / datapath registers
   // ------------------------------------------------------------------------
   logic [2:0]    r_state;
   logic [AW-1:0] r_len;
   logic [AW-1:0] r_pidx;
   logic [SW-1:0] r_sym;        // symbol sweep index for CLEAR and PREFIX
   logic [AW-1:0] r_i;          // L-buffer sweep index for RANK
   logic [AW-1:0] r_sum;        // running exclusive prefix sum
   logic [AW-1:0] r_idx;        // current row in the LF walk
   logic [AW-1:0] r_k;          // output position of the next symbol
   logic [AW-1:0] r_remaining;  // symbols still to emit
   logic          r_busy;
   logic [SW-1:0] r_outstring;
   logic [AW-1:0] r_out_adr;
   logic          r_out_valid;
   logic          r_done;
   logic          r_err;

   logic          w_idle_like;
   logic          w_load_we;
   logic          w_accept;
   logic [SW-1:0] w_rank_sym;
   logic [AW-1:0] w_rank_val;
   logic [SW-1:0] w_dec_sym;
   logic [AW-1:0] w_next_idx;

   assign w_idle_like = (r_state == c_IDLE) || (r_state == c_DONE);
   assign w_load_we   = en && w_idle_like;
   // A start that coincides with a load strobe is dropped.
   assign w_accept    = start && !en && w_idle_like;

   assign w_rank_sym  = r_lbuf[r_i];
   assign w_rank_val  = r_cnt[w_rank_sym];

   // LF mapping: row of L[idx] in the first column = C[L[idx]] + rank[idx]
   assign w_dec_sym   = r_lbuf[r_idx];
   assign w_next_idx  = r_cnt[w_dec_sym] + r_rank[r_idx];

   // ------------------------------------------------------------------------
   // Memory writes (no reset: contents persist across decodes)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_load_we) begin
         r_lbuf[adr] <= in_string;
      end
      if (r_state == c_CLEAR) begin
         r_cnt[r_sym] <= '0;
      end else if (r_state == c_RANK) begin
         r_rank[r_i]        <= w_rank_val;
         r_cnt[w_rank_sym]  <= w_rank_val + c_A_ONE;
      end else if (r_state == c_PREFIX) begin
         r_cnt[r_sym] <= r_sum;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_len       <= '0;
         r_pidx      <= '0;
         r_sym       <= '0;
         r_i         <= '0;
         r_sum       <= '0;
         r_idx       <= '0;
         r_k         <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_outstring <= '0;
         r_out_adr   <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            c_IDLE, c_DONE: begin
               if (w_accept) begin
                  r_len   <= length;
                  r_pidx  <= primary_idx;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_sym   <= '0;
                  r_state <= c_CLEAR;
               end
            end

            c_CLEAR: begin
               // Degenerate requests are resolved on the first CLEAR cycle.
               if (r_len == '0) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= c_DONE;
               end else if (r_pidx >= r_len) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= c_DONE;
               end else begin
                  r_sym <= r_sym + c_S_ONE;
                  if (r_sym == c_SYM_LAST) begin
                     r_i     <= '0;
                     r_state <= c_RANK;
                  end
               end
            end

            c_RANK: begin
               r_i <= r_i + c_A_ONE;
               if (r_i == r_len - c_A_ONE) begin
                  r_sym   <= '0;
                  r_sum   <= '0;
                  r_state <= c_PREFIX;
               end
            end

            c_PREFIX: begin
               r_sum <= r_sum + r_cnt[r_sym];
               r_sym <= r_sym + c_S_ONE;
               if (r_sym == c_SYM_LAST) begin
                  r_idx       <= r_pidx;
                  r_k         <= r_len - c_A_ONE;
                  r_remaining <= r_len;
                  r_state     <= c_DECODE;
               end
            end

            c_DECODE: begin
               // n emitting cycles, then one closing cycle that raises done.
               if (r_remaining != '0) begin
                  r_out_valid <= 1'b1;
                  r_outstring <= w_dec_sym;
                  r_out_adr   <= r_k;
                  r_idx       <= w_next_idx;
                  r_k         <= r_k - c_A_ONE;
                  r_remaining <= r_remaining - c_A_ONE;
               end else begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= c_DONE;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign outstring = r_outstring;
   assign out_adr   = r_out_adr;
   assign out_valid = r_out_valid;
   assign done_flag = r_done;
   assign err       = r_err;

endmodule
`default_nettype wire
